// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults and the instruction buffer entry type for the fetch unit.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
    localparam int unsigned FIFO_DEPTH_DEFAULT = 2;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small register-based instruction buffer with flush.
// Flush has priority over push/pop; a push into a full buffer is accepted only with a pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_push,
    input  fetch_entry_t               i_wdata,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output fetch_entry_t               o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    // Storage, pointers and occupancy; clearing storage on reset keeps the head output at zero.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with a small buffer, redirect flush and response discard.
// Optional macro FETCH_MISALIGN_TRAP_EN adds a sticky misalign_trap output that halts fetching.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        misalign_trap
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]   r_pc;
    logic [31:0]   r_rsp_pc;      // address of the next response that will be kept
    logic [CW-1:0] r_outstanding; // all in-flight requests, including those to discard
    logic [CW-1:0] r_discard;     // oldest in-flight requests whose responses are dropped
    logic [31:0]   w_redirect_pc;
    logic          w_trap;
    logic          w_req_fire;
    logic          w_rsp_drop;
    logic          w_push;
    logic          w_pop;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [CW-1:0] w_fifo_count;
    logic [CW-1:0] w_outstanding_d;
    logic [CW:0]   w_inflight;
    fetch_entry_t  w_wdata;
    fetch_entry_t  w_head;
    logic          w_unused;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_trap;

    // Sticky trap on any misaligned redirect target; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_trap <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            r_trap <= 1'b1;
        end
    end

    assign w_redirect_pc = redirect_pc;
    assign w_trap        = r_trap;
    assign misalign_trap = r_trap;
    assign w_unused      = w_fifo_full;
`else
    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
    assign w_trap        = 1'b0;
    assign w_unused      = ^{w_fifo_full, redirect_pc[1:0]};
`endif

    // Occupancy plus in-flight requests bounds issue so every response always has a slot.
    assign w_inflight      = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
    assign imem_req_valid  = !reset && !w_trap && (w_inflight < (CW + 1)'(FIFO_DEPTH));
    assign imem_req_addr   = r_pc;
    assign w_req_fire      = imem_req_valid && imem_req_ready;
    assign w_rsp_drop      = imem_rsp_valid && (r_discard != '0);
    assign w_push          = imem_rsp_valid && !w_rsp_drop && !redirect_valid;
    assign w_pop           = inst_valid && inst_ready && !redirect_valid;
    assign w_outstanding_d = r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid);
    assign w_wdata         = '{inst: imem_rsp_data, pc: r_rsp_pc};

    assign inst_valid = !w_fifo_empty;
    assign inst       = w_head.inst;
    assign inst_pc    = w_head.pc;

    // Fetch PC, response address and request accounting; a redirect overrides everything else.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= w_outstanding_d;
            if (redirect_valid) begin
                r_pc      <= w_redirect_pc;
                r_rsp_pc  <= w_redirect_pc;
                r_discard <= w_outstanding_d;
            end else begin
                if (w_req_fire) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                end
                if (w_rsp_drop) begin
                    r_discard <= r_discard - 1'b1;
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_reset (reset),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 2, instruction buffer entries and maximum outstanding requests.
REQ-003 SHALL have port clk, input, 1, sole clock, rising-edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-005 SHALL have port redirect_valid, input, 1, taken branch or jump (PCSrc from the controller).
REQ-006 SHALL have port redirect_pc, input, 32, target address qualified by redirect_valid.
REQ-007 SHALL have port imem_req_valid, output, 1, fetch request valid.
REQ-008 SHALL have port imem_req_ready, input, 1, memory accepts request.
REQ-009 SHALL have port imem_req_addr, output, 32, fetch address.
REQ-010 SHALL have port imem_rsp_valid, input, 1, in-order response valid, 1 or more cycles after acceptance.
REQ-011 SHALL have port imem_rsp_data, input, 32, fetched instruction word.
REQ-012 SHALL have port inst_valid, output, 1, instruction available to decode.
REQ-013 SHALL have port inst_ready, input, 1, decode consumes instruction.
REQ-014 SHALL have ports inst (output, 32, instruction word) and inst_pc (output, 32, its address).

Function
REQ-015 SHALL hold a 32-bit fetch PC; a request handshake occurs when imem_req_valid and imem_req_ready are both high; each handshake advances the PC by 4, wrapping 32'hFFFF_FFFC to 32'h0.
REQ-016 SHALL assert imem_req_valid only when FIFO occupancy plus outstanding requests is less than FIFO_DEPTH.
REQ-017 SHALL hold imem_req_addr stable while imem_req_valid is high and imem_req_ready is low, except on redirect.
REQ-018 SHALL push {imem_rsp_data, request address} into the FIFO on each non-discarded response; responses are never back-pressured.
REQ-019 SHALL drive inst and inst_pc from the FIFO head, with inst_valid high when the FIFO is non-empty; the entry pops on inst_valid and inst_ready.
REQ-020 SHALL give a latency of one cycle from an accepted response to inst_valid (registered FIFO write, no bypass).
REQ-021 On redirect_valid, SHALL in the same edge flush the FIFO, load the PC with redirect_pc, and record all outstanding requests as to-discard.
REQ-022 SHALL drop (never push) responses counted as to-discard, decrementing the discard counter per response.
REQ-023 SHALL let redirect win over a simultaneous pop, push, or request handshake; the address of a request accepted in the redirect cycle is counted as to-discard.
REQ-024 SHALL present imem_req_valid with addr = redirect_pc in the cycle after a redirect, subject to REQ-016 with the FIFO treated as empty.
REQ-025 SHALL support a simultaneous push and pop at full occupancy, with occupancy unchanged.

Reset
REQ-026 On reset assertion, SHALL asynchronously set the PC to RESET_PC, FIFO empty, outstanding=0, discard=0, imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0.
REQ-027 SHALL assert imem_req_valid with imem_req_addr=RESET_PC in the first cycle after reset deasserts; responses arriving during reset are ignored.

Configuration
REQ-028 With FETCH_MISALIGN_TRAP_EN defined, SHALL add output misalign_trap (1 bit); a redirect_pc with bits[1:0] != 0 sets it, sticky until reset, and stops requests; without the macro, redirect_pc[1:0] are forced to 0 and the port does not exist.

Structure
REQ-029 SHALL place RESET_PC default, FIFO_DEPTH default, and typedef fetch_entry_t {inst[31:0], pc[31:0]} in package fetch_pkg.
REQ-030 SHALL implement the buffer as sub-module fetch_fifo (parameterised depth, push/pop/flush, full/empty/count).

Verification
REQ-031 Reset release, ready=1, 1-cycle response -> requests at 0x0, 0x4, 0x8; inst_pc 0x0 then 0x4 then 0x8, one per cycle after the first.
REQ-032 inst_ready=0 for 10 cycles -> exactly 2 requests issued, FIFO full, imem_req_valid low until the first pop.
REQ-033 Redirect to 0x100 with 2 outstanding -> both responses discarded, next inst_pc=0x100.
REQ-034 imem_req_ready=0 for 3 cycles -> imem_req_addr constant; redirect in cycle 2 -> addr becomes redirect_pc.
REQ-035 Redirect to 0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0.
REQ-036 Macro defined, redirect to 0x102 -> misalign_trap=1, no further requests; macro undefined -> fetch at 0x100.
